// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : RV32I fetch stage with PC, valid-handshake fetch and pre-decode.
//            Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic        next_sel,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        r_type,
  output logic        i_type,
  output logic        load,
  output logic        store,
  output logic        branch,
  output logic        jal,
  output logic [2:0]  fun3,
  output logic        fun7,
  output logic        illegal,
  output logic        misalign,
  output logic        fetch_err
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_I      = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("instr_fetch_unit: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_misalign;
  logic        w_accept;
  logic        w_retire;
  logic        w_expire;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          w_retire    = 1'b1;
          w_pc_nxt    = next_sel ? {target[31:2], 2'b00} : r_pc + 32'd4;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_fetch_err;

  // A response arriving on the final watchdog cycle wins over the timeout.
  assign w_expire = (r_state == S_FETCH) && r_req && !imem_valid &&
                    (r_tmo_cnt == C_TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt   <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_expire;
      if ((r_state == S_FETCH) && r_req && !imem_valid && !w_expire)
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      else
        r_tmo_cnt <= 8'd0;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_expire  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Request is registered so it stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_req      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req      <= (w_state_nxt == S_FETCH) && !w_expire;
      r_misalign <= w_retire && next_sel && (target[1:0] != 2'b00);
      if (w_accept)
        r_instr <= imem_rdata;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_HOLD);
  assign misalign    = r_misalign;

  always_comb begin
    r_type  = 1'b0;
    i_type  = 1'b0;
    load    = 1'b0;
    store   = 1'b0;
    branch  = 1'b0;
    jal     = 1'b0;
    illegal = 1'b0;
    fun3    = 3'b000;
    fun7    = 1'b0;
    if (instr_valid) begin
      fun3 = r_instr[14:12];
      case (r_instr[6:0])
        C_OP_R:      r_type  = 1'b1;
        C_OP_I:      i_type  = 1'b1;
        C_OP_LOAD:   load    = 1'b1;
        C_OP_STORE:  store   = 1'b1;
        C_OP_BRANCH: branch  = 1'b1;
        C_OP_JAL:    jal     = 1'b1;
        default:     illegal = 1'b1;
      endcase
      // Bit 30 is an immediate bit for most I-type ops; only shifts use it as funct7.
      if (r_type || (i_type && (r_instr[13:12] == 2'b01)))
        fun7 = r_instr[30];
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RV32I core: holds the program counter and fetches one instruction at a time from instruction memory over a valid handshake. It presents the latched instruction along with pre-decoded opcode-class flags, `fun3` and `fun7`, which feed the control decoder directly. On retire it advances the PC to PC+4 or to a redirect target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 16, fetch watchdog limit; used only with `FETCH_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_valid`  in  1  read data valid for the outstanding request.
- `imem_rdata`  in  32  instruction word.
- `retire`  in  1  core has finished the presented instruction.
- `next_sel`  in  1  redirect on this retire; driven from the decoder's `next_sel` gated by the branch outcome.
- `target`  in  32  redirect address.
- `pc`  out  32  address of the current instruction.
- `instr`  out  32  latched instruction.
- `instr_valid`  out  1  `instr` and the flags are valid.
- `r_type`, `i_type`, `load`, `store`, `branch`, `jal`  out  1 each  opcode class flags.
- `fun3`  out  3  `instr[14:12]`.
- `fun7`  out  1  `instr[30]`, qualified as described under Operation.
- `illegal`  out  1  opcode is not one of the six classes.
- `misalign`  out  1  one-cycle pulse when a redirect target has non-zero bits [1:0].
- `fetch_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Two-state FSM:
  - FETCH: `imem_req`=1, waiting for `imem_valid`.
  - HOLD: `instr_valid`=1, waiting for `retire`.
- FETCH + `imem_valid`: latch `imem_rdata` into `instr`, go to HOLD.
- HOLD + `retire`:
  - `next_sel`=1: `pc` <= {`target[31:2]`, 2'b00}; `misalign` pulses if `target[1:0]`≠0.
  - `next_sel`=0: `pc` <= `pc`+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Go to FETCH.
- `imem_valid` outside FETCH is ignored. `retire` outside HOLD is ignored, including any accompanying `next_sel`.
- Decode from `instr[6:0]`:
  - 0110011 → `r_type`
  - 0010011 → `i_type`
  - 0000011 → `load`
  - 0100011 → `store`
  - 1100011 → `branch`
  - 1101111 → `jal`
  - anything else → `illegal`
  - Exactly one of the seven outputs is 1 while `instr_valid`=1. All are 0 while `instr_valid`=0.
- `fun7` = `instr[30]` for `r_type`, and for `i_type` with `fun3` of 001 or 101 (shifts). Otherwise `fun7`=0, so immediate bits never reach the decoder as `fun7`.
- Flags and `fun3`/`fun7` are combinational from the registered `instr` and gated by `instr_valid`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH, `instr`=0.
  - `instr_valid`, `misalign`, `fetch_err` = 0.
  - `imem_req`=0 while `rst`=0.
- `imem_req` rises on the first clock edge after `rst` deasserts.
- Fetch latency: `instr_valid` rises on the edge that samples `imem_valid`=1. Minimum FETCH dwell is 1 cycle.
- Retire-to-request: `imem_req` is 1 with the new `imem_addr` in the cycle after the retire edge. Back-to-back throughput is 1 instruction per 2 cycles with a zero-wait memory.
- `imem_addr` is stable while `imem_req`=1.
- `instr` is stable for the whole HOLD period.
- Reset mid-fetch abandons the request. Instruction memory must not return data for a request abandoned by reset.
- `imem_valid` and `retire` in the same cycle: only the term for the current state acts.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in FETCH and clears on entering FETCH.
  - On reaching `TIMEOUT_CYCLES` with no `imem_valid`: `fetch_err` pulses for one cycle, `imem_req` drops for that cycle, then the request re-issues at the same `pc` and the counter clears.
  - `imem_valid` on the expiry cycle is accepted and suppresses the error.
- `FETCH_TIMEOUT_EN` undefined: no counter; `fetch_err` is tied 0; FETCH waits indefinitely.

## Test plan
- Reset release, memory returns 32'h0020_8133 one cycle after request → `pc`=0, `instr_valid`=1, `r_type`=1, `fun3`=000, `fun7`=0.
- Retire with `next_sel`=0 at `pc`=32'hFFFF_FFFC → next `imem_addr`=0.
- Retire with `next_sel`=1, `target`=32'h0000_0106 → `pc`=32'h104, `misalign` pulses one cycle.
- `instr`=32'h4010_5093 (srai) → `i_type`=1, `fun3`=101, `fun7`=1. `instr`=32'h4000_0093 (addi, imm bit 30 set) → `fun7`=0.
- `rst` asserted while waiting on memory, then released → `pc`=`RESET_PC`, `instr_valid`=0, fresh request; `retire` pulses in FETCH are ignored.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, memory silent → `fetch_err` pulses every 5 cycles and `imem_addr` is unchanged. Without the macro → `fetch_err` stays 0.
